// File: rtl/hls_macc_pkg.sv
// -----------------------------------------------------------------------------
// hls_macc_pkg
// Shared definitions for the HLS MACC result collector: the result record
// layout, its packed width, and the default sizing parameters.
// -----------------------------------------------------------------------------
package hls_macc_pkg;

  // Packed record width: three 32-bit words plus the mismatch flag.
  localparam int REC_W     = 97;
  localparam int DEPTH_DEF = 4;
  localparam int ACC_W_DEF = 64;

  // One collected MACC result. err flags o1+o2 (mod 2^32) disagreeing with ret.
  typedef struct packed {
    logic [31:0] o1;
    logic [31:0] o2;
    logic [31:0] ret;
    logic        err;
  } res_rec_t;

endpackage

// File: rtl/hls_macc_res_fifo.sv
// -----------------------------------------------------------------------------
// hls_macc_res_fifo
// DEPTH-entry record FIFO built from flops. The head entry is presented
// straight from the storage registers, so valid_o rises on the edge after the
// first push (no write-to-read bypass).
//
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset (empties FIFO, zeroes storage)
//   push_i     write wr_data_i at the tail (honoured when not full, or full
//              with a same-edge pop)
//   wr_data_i  record to write
//   pop_i      drop the head entry (honoured when not empty)
//   rd_data_o  head record
//   valid_o    FIFO holds at least one entry
//   count_o    number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module hls_macc_res_fifo
  import hls_macc_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [REC_W-1:0]           wr_data_i,
  input  logic                       pop_i,
  output logic [REC_W-1:0]           rd_data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  logic do_pop;
  logic do_push;

  assign do_pop  = pop_i & (count_q != '0);
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_push = push_i & ((count_q != FULL_CNT) | do_pop);

  // DEPTH is a power of two, so the PW-bit pointers wrap on their own.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign valid_o   = (count_q != '0);
  assign count_o   = count_q;

endmodule

// File: rtl/hls_macc_result_collector.sv
// -----------------------------------------------------------------------------
// hls_macc_result_collector
// Captures results of an HLS MACC core (o1, o2, ap_return) on ap_done, checks
// o1+o2 against ap_return, queues the records for a ready/valid consumer and
// keeps a saturating signed running sum of ap_return plus status counters.
//
// Ports:
//   ap_clk, ap_rst_n            clock, asynchronous active-low reset
//   in_done, in_o1(_vld),
//   in_o2(_vld), in_ret         upstream MACC outputs
//   start_allow                 upstream may start a new call (FIFO has room)
//   m_valid, m_ready            downstream handshake
//   m_o1, m_o2, m_ret, m_err    head record
//   acc                         saturating signed sum of accepted in_ret
//   txn_cnt, drop_cnt           accepted / dropped (FIFO full) captures
//   err_sticky, proto_err       mismatch seen / done without both vlds
//   clr                         synchronous clear of acc and status
// -----------------------------------------------------------------------------
module hls_macc_result_collector
  import hls_macc_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             in_done,
  input  logic [31:0]      in_o1,
  input  logic             in_o1_vld,
  input  logic [31:0]      in_o2,
  input  logic             in_o2_vld,
  input  logic [31:0]      in_ret,
  output logic             start_allow,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_o1,
  output logic [31:0]      m_o2,
  output logic [31:0]      m_ret,
  output logic             m_err,
  output logic [ACC_W-1:0] acc,
  output logic [15:0]      txn_cnt,
  output logic [7:0]       drop_cnt,
  output logic             err_sticky,
  output logic             proto_err,
  input  logic             clr
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  logic             capture;
  logic             proto_evt;
  logic             pop;
  logic             push;
  logic             drop;
  logic             full;
  logic             fifo_valid;
  logic [CW-1:0]    fifo_count;
  logic [REC_W-1:0] head_bits;
  res_rec_t         head_rec;
  res_rec_t         in_rec;

  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_sat;

  logic [ACC_W-1:0] acc_q,    acc_d;
  logic [15:0]      txn_q,    txn_d;
  logic [7:0]       drop_q,   drop_d;
  logic             sticky_q, sticky_d;
  logic             proto_q,  proto_d;

  assign capture   = in_done & in_o1_vld & in_o2_vld;
  assign proto_evt = in_done & ~(in_o1_vld & in_o2_vld);
  assign full      = (fifo_count == FULL_CNT);
  assign pop       = fifo_valid & m_ready;
  assign push      = capture & (~full | pop);
  assign drop      = capture & full & ~pop;

  always_comb begin
    in_rec.o1  = in_o1;
    in_rec.o2  = in_o2;
    in_rec.ret = in_ret;
    // 32-bit context: the sum wraps mod 2^32 before the compare.
    in_rec.err = ((in_o1 + in_o2) != in_ret);
  end

  hls_macc_res_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (ap_clk),
    .rst_ni    (ap_rst_n),
    .push_i    (push),
    .wr_data_i (in_rec),
    .pop_i     (pop),
    .rd_data_o (head_bits),
    .valid_o   (fifo_valid),
    .count_o   (fifo_count)
  );

  assign head_rec    = res_rec_t'(head_bits);
  assign m_valid     = fifo_valid;
  assign m_o1        = head_rec.o1;
  assign m_o2        = head_rec.o2;
  assign m_ret       = head_rec.ret;
  assign m_err       = head_rec.err;
  assign start_allow = (fifo_count < FULL_CNT);

  // One guard bit catches signed overflow: the top two bits of the widened
  // sum disagree exactly when the true result left the ACC_W range.
  always_comb begin
    acc_sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-31){in_ret[31]}}, in_ret};
    if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
      acc_sat = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_sat = acc_sum[ACC_W-1:0];
    end
  end

  always_comb begin
    acc_d    = acc_q;
    txn_d    = txn_q;
    drop_d   = drop_q;
    sticky_d = sticky_q;
    proto_d  = proto_q;
    if (clr) begin
      acc_d    = '0;
      txn_d    = '0;
      drop_d   = '0;
      sticky_d = 1'b0;
      proto_d  = 1'b0;
    end else begin
      if (push) begin
        acc_d = acc_sat;
        txn_d = txn_q + 16'd1;
        if (in_rec.err) begin
          sticky_d = 1'b1;
        end
      end
      if (drop && (drop_q != 8'hFF)) begin
        drop_d = drop_q + 8'd1;
      end
      if (proto_evt) begin
        proto_d = 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q    <= '0;
      txn_q    <= '0;
      drop_q   <= '0;
      sticky_q <= 1'b0;
      proto_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      txn_q    <= txn_d;
      drop_q   <= drop_d;
      sticky_q <= sticky_d;
      proto_q  <= proto_d;
    end
  end

  assign acc        = acc_q;
  assign txn_cnt    = txn_q;
  assign drop_cnt   = drop_q;
  assign err_sticky = sticky_q;
  assign proto_err  = proto_q;

endmodule

// File: tb/tb_hls_macc_result_collector.sv
// -----------------------------------------------------------------------------
// tb_hls_macc_result_collector
// Self-checking bench: a table of directed vectors, hand-written multi-cycle
// sequences, then randomized traffic compared against a queue-based model.
// -----------------------------------------------------------------------------
module tb_hls_macc_result_collector;

  localparam int DEPTH = 4;
  localparam int ACC_W = 34;
  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));

  logic             ap_clk = 1'b0;
  logic             ap_rst_n = 1'b0;
  logic             in_done = 1'b0;
  logic [31:0]      in_o1 = '0;
  logic             in_o1_vld = 1'b0;
  logic [31:0]      in_o2 = '0;
  logic             in_o2_vld = 1'b0;
  logic [31:0]      in_ret = '0;
  logic             start_allow;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [31:0]      m_o1, m_o2, m_ret;
  logic             m_err;
  logic [ACC_W-1:0] acc;
  logic [15:0]      txn_cnt;
  logic [7:0]       drop_cnt;
  logic             err_sticky;
  logic             proto_err;
  logic             clr = 1'b0;

  hls_macc_result_collector #(
    .DEPTH (DEPTH),
    .ACC_W (ACC_W)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .in_done     (in_done),
    .in_o1       (in_o1),
    .in_o1_vld   (in_o1_vld),
    .in_o2       (in_o2),
    .in_o2_vld   (in_o2_vld),
    .in_ret      (in_ret),
    .start_allow (start_allow),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_o1        (m_o1),
    .m_o2        (m_o2),
    .m_ret       (m_ret),
    .m_err       (m_err),
    .acc         (acc),
    .txn_cnt     (txn_cnt),
    .drop_cnt    (drop_cnt),
    .err_sticky  (err_sticky),
    .proto_err   (proto_err),
    .clr         (clr)
  );

  always #5 ap_clk = ~ap_clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit [31:0] o1;
    bit [31:0] o2;
    bit [31:0] ret;
    bit        err;
  } rec_t;

  rec_t   mq[$];
  longint m_acc;
  int     m_txn;
  int     m_drop;
  bit     m_sticky;
  bit     m_proto;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic longint acc_now();
    return longint'($signed(acc));
  endfunction

  task automatic model_reset();
    mq.delete();
    m_acc = 0; m_txn = 0; m_drop = 0; m_sticky = 0; m_proto = 0;
  endtask

  // Applies one clock edge worth of rules to the model, using the inputs the
  // bench is currently driving.
  task automatic model_edge();
    rec_t   r;
    bit     cap, prot, pop, push;
    longint s;
    cap  = in_done && in_o1_vld && in_o2_vld;
    prot = in_done && !(in_o1_vld && in_o2_vld);
    pop  = (mq.size() != 0) && m_ready;
    push = cap && ((mq.size() < DEPTH) || pop);
    r.o1  = in_o1;
    r.o2  = in_o2;
    r.ret = in_ret;
    r.err = ((longint'(in_o1) + longint'(in_o2)) % (longint'(1) <<< 32)) != longint'(in_ret);
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(r);
    if (clr) begin
      m_acc = 0; m_txn = 0; m_drop = 0; m_sticky = 0; m_proto = 0;
    end else begin
      if (push) begin
        m_txn = (m_txn + 1) % 65536;
        if (r.err) m_sticky = 1;
        s = m_acc + longint'($signed(in_ret));
        if (s > ACC_MAX) s = ACC_MAX;
        if (s < ACC_MIN) s = ACC_MIN;
        m_acc = s;
      end
      if (cap && !push && m_drop < 255) m_drop++;
      if (prot) m_proto = 1;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".m_valid"}, m_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check({tag, ".m_o1"},  m_o1,  mq[0].o1);
      check({tag, ".m_o2"},  m_o2,  mq[0].o2);
      check({tag, ".m_ret"}, m_ret, mq[0].ret);
      check({tag, ".m_err"}, m_err, mq[0].err);
    end
    check({tag, ".acc"},         acc_now(),  m_acc);
    check({tag, ".txn_cnt"},     txn_cnt,    m_txn);
    check({tag, ".drop_cnt"},    drop_cnt,   m_drop);
    check({tag, ".err_sticky"},  err_sticky, m_sticky);
    check({tag, ".proto_err"},   proto_err,  m_proto);
    check({tag, ".start_allow"}, start_allow, mq.size() < DEPTH);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit done, input bit v1, input bit v2,
                       input logic [31:0] o1, input logic [31:0] o2,
                       input logic [31:0] ret, input bit ready, input bit c);
    in_done = done; in_o1_vld = v1; in_o2_vld = v2;
    in_o1 = o1; in_o2 = o2; in_ret = ret;
    m_ready = ready; clr = c;
  endtask

  task automatic idle(input bit ready, input bit c);
    drive(0, 0, 0, 32'd0, 32'd0, 32'd0, ready, c);
  endtask

  task automatic cap(input logic [31:0] o1, input logic [31:0] o2,
                     input logic [31:0] ret, input bit ready);
    drive(1, 1, 1, o1, o2, ret, ready, 0);
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge ap_clk);
    model_edge();
    #1;
  endtask

  // Asserts reset between edges and checks the outputs before any clock.
  task automatic do_reset(input string tag);
    idle(0, 0);
    ap_rst_n = 1'b0;
    #2;
    model_reset();
    check({tag, ".rst.m_valid"},     m_valid,     0);
    check({tag, ".rst.m_o1"},        m_o1,        0);
    check({tag, ".rst.m_o2"},        m_o2,        0);
    check({tag, ".rst.m_ret"},       m_ret,       0);
    check({tag, ".rst.m_err"},       m_err,       0);
    check({tag, ".rst.acc"},         acc_now(),   0);
    check({tag, ".rst.txn_cnt"},     txn_cnt,     0);
    check({tag, ".rst.drop_cnt"},    drop_cnt,    0);
    check({tag, ".rst.err_sticky"},  err_sticky,  0);
    check({tag, ".rst.proto_err"},   proto_err,   0);
    check({tag, ".rst.start_allow"}, start_allow, 1);
    ap_rst_n = 1'b1;
    $display("reset %s done", tag);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          done, v1, v2, ready, c;
    logic [31:0] o1, o2, ret;
    bit          e_valid, e_err, e_sticky, e_proto, e_start;
    longint      e_acc;
    int          e_txn, e_drop;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // fields: done v1 v2 ready clr | o1 o2 ret | valid err sticky proto start | acc txn drop
    vecs[0] = '{1,1,1,1,0, 32'd5, 32'd7, 32'd12, 1,0,0,0,1, 12, 1, 0}; // single capture
    vecs[1] = '{0,0,0,1,0, 32'd0, 32'd0, 32'd0,  0,0,0,0,1, 12, 1, 0}; // pop it
    vecs[2] = '{0,0,0,0,1, 32'd0, 32'd0, 32'd0,  0,0,0,0,1, 0,  0, 0}; // clr
    vecs[3] = '{1,1,1,0,0, 32'd1, 32'd1, 32'd3,  1,1,1,0,1, 3,  1, 0}; // mismatch
    vecs[4] = '{0,0,0,1,1, 32'd0, 32'd0, 32'd0,  0,0,0,0,1, 0,  0, 0}; // clr + pop
    vecs[5] = '{1,1,1,0,1, 32'd2, 32'd3, 32'd5,  1,0,0,0,1, 0,  0, 0}; // clr wins, push kept
    vecs[6] = '{0,0,0,1,0, 32'd0, 32'd0, 32'd0,  0,0,0,0,1, 0,  0, 0}; // pop
    vecs[7] = '{1,1,0,0,0, 32'd9, 32'd9, 32'd18, 0,0,0,1,1, 0,  0, 0}; // done w/o o2 vld
    vecs[8] = '{0,0,0,0,1, 32'd0, 32'd0, 32'd0,  0,0,0,0,1, 0,  0, 0}; // clr proto_err

    model_reset();
    #1;
    // Reset is asserted from time 0, before any clock edge.
    check("init.m_valid",     m_valid,     0);
    check("init.acc",         acc_now(),   0);
    check("init.txn_cnt",     txn_cnt,     0);
    check("init.start_allow", start_allow, 1);
    #10;
    ap_rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].done, vecs[i].v1, vecs[i].v2, vecs[i].o1, vecs[i].o2,
            vecs[i].ret, vecs[i].ready, vecs[i].c);
      step();
      $display("vec %0d: done=%0b o1=%0d o2=%0d ret=%0d clr=%0b -> valid=%0b acc=%0d txn=%0d",
               i, vecs[i].done, vecs[i].o1, vecs[i].o2, vecs[i].ret, vecs[i].c,
               m_valid, acc_now(), txn_cnt);
      check($sformatf("vec%0d.m_valid", i),     m_valid,     vecs[i].e_valid);
      if (vecs[i].e_valid) check($sformatf("vec%0d.m_err", i), m_err, vecs[i].e_err);
      check($sformatf("vec%0d.acc", i),         acc_now(),   vecs[i].e_acc);
      check($sformatf("vec%0d.txn_cnt", i),     txn_cnt,     vecs[i].e_txn);
      check($sformatf("vec%0d.drop_cnt", i),    drop_cnt,    vecs[i].e_drop);
      check($sformatf("vec%0d.err_sticky", i),  err_sticky,  vecs[i].e_sticky);
      check($sformatf("vec%0d.proto_err", i),   proto_err,   vecs[i].e_proto);
      check($sformatf("vec%0d.start_allow", i), start_allow, vecs[i].e_start);
    end

    // ---------- overflow: 5 captures into a 4-deep FIFO, then drain ----------
    do_reset("ovf");
    for (int i = 1; i <= 5; i++) begin
      cap(32'(i), 32'(10 * i), 32'(11 * i), 0);
      step();
      $display("ovf capture %0d: start_allow=%0b drop=%0d", i, start_allow, drop_cnt);
      if (i == 3) check("ovf.start_allow_3", start_allow, 1);
      if (i == 4) check("ovf.start_allow_4", start_allow, 0);
    end
    check("ovf.drop_cnt", drop_cnt, 1);
    check("ovf.txn_cnt",  txn_cnt,  4);
    check("ovf.acc",      acc_now(), 110);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovf.drain%0d.m_valid", i), m_valid, 1);
      check($sformatf("ovf.drain%0d.m_o1", i),    m_o1,    i);
      check($sformatf("ovf.drain%0d.m_ret", i),   m_ret,   11 * i);
      idle(1, 0);
      step();
      $display("ovf drain %0d", i);
    end
    check("ovf.empty", m_valid, 0);
    check("ovf.start_allow_end", start_allow, 1);

    // ---------- full FIFO with a same-edge push and pop ----------
    do_reset("fpp");
    for (int i = 21; i <= 24; i++) begin
      cap(32'(i), 32'd0, 32'(i), 0);
      step();
    end
    check("fpp.full", start_allow, 0);
    cap(32'd25, 32'd0, 32'd25, 1);
    step();
    $display("fpp push+pop: head=%0d start_allow=%0b", m_o1, start_allow);
    check("fpp.start_allow", start_allow, 0);
    check("fpp.drop_cnt",    drop_cnt,    0);
    check("fpp.txn_cnt",     txn_cnt,     5);
    for (int i = 22; i <= 25; i++) begin
      check($sformatf("fpp.drain%0d.m_o1", i), m_o1, i);
      idle(1, 0);
      step();
    end
    check("fpp.empty", m_valid, 0);

    // ---------- accumulator saturation ----------
    do_reset("sat");
    for (int i = 0; i < 5; i++) begin
      cap(32'h7FFF_FFFF, 32'd0, 32'h7FFF_FFFF, 1);
      step();
      $display("sat add %0d: acc=%0d", i, acc_now());
    end
    check("sat.acc_max", acc_now(), 64'd8589934591);
    check("sat.m_err",   m_err,     0);
    cap(32'h8000_0000, 32'd0, 32'h8000_0000, 1);
    step();
    $display("sat add negative: acc=%0d", acc_now());
    check("sat.acc_after_neg", acc_now(), 64'd6442450943);

    // ---------- drop counter saturation ----------
    do_reset("dsat");
    for (int i = 0; i < 262; i++) begin
      cap(32'(i), 32'd1, 32'(i + 1), 0);
      step();
    end
    $display("dsat: drop=%0d txn=%0d", drop_cnt, txn_cnt);
    check("dsat.drop_cnt", drop_cnt, 255);
    check("dsat.txn_cnt",  txn_cnt,  4);

    // ---------- protocol error, then reset with records stored ----------
    do_reset("prot");
    drive(1, 1, 0, 32'd4, 32'd4, 32'd8, 0, 0);
    step();
    $display("prot: done with o2_vld low -> valid=%0b proto_err=%0b", m_valid, proto_err);
    check("prot.m_valid",   m_valid,   0);
    check("prot.proto_err", proto_err, 1);
    check("prot.txn_cnt",   txn_cnt,   0);
    cap(32'd3, 32'd4, 32'd7, 0);
    step();
    cap(32'd5, 32'd6, 32'd11, 0);
    step();
    check("prot.two_stored", txn_cnt, 2);
    do_reset("midrun");
    cap(32'd8, 32'd9, 32'd17, 0);
    #1;
    check("post_rst.no_bypass", m_valid, 0);
    step();
    $display("post reset capture: valid=%0b o1=%0d", m_valid, m_o1);
    check("post_rst.m_valid", m_valid, 1);
    check("post_rst.m_o1",    m_o1,    8);
    check("post_rst.txn_cnt", txn_cnt, 1);

    // ---------- randomized traffic against the model ----------
    do_reset("rand");
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] o1, o2, ret;
      bit done, v1, v2, ready, c;
      int sel;
      done  = ($urandom_range(0, 99) < 55);
      v1    = ($urandom_range(0, 99) < 90);
      v2    = ($urandom_range(0, 99) < 90);
      ready = ($urandom_range(0, 99) < 45);
      c     = ($urandom_range(0, 99) < 2);
      o1    = $urandom;
      o2    = $urandom;
      sel   = $urandom_range(0, 3);
      case (sel)
        0:       ret = o1 + o2;
        1:       ret = 32'h7FFF_FFFF;
        2:       ret = 32'h8000_0000 | $urandom_range(0, 255);
        default: ret = $urandom;
      endcase
      drive(done, v1, v2, o1, o2, ret, ready, c);
      step();
      check_model($sformatf("rand%0d", i));
    end
    $display("random phase: %0d cycles, final txn=%0d drop=%0d acc=%0d",
             3000, txn_cnt, drop_cnt, acc_now());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
